// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage for the single-cycle MIPS core. Owns the program
//   counter and requests instruction words from a variable-latency memory over
//   a req/ack handshake. Each word goes to the decoder over a valid/ready
//   handshake. When the decoder consumes the word, the next PC is computed from
//   pc_src, the ALU branch outcome, the branch offset and the jump field.
//
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     imem_req/addr       request to instruction memory (addr == pc)
//     imem_ack/rdata      memory response; rdata valid when ack = 1
//     inst/inst_valid     fetched word to decoder, held until inst_ready
//     inst_ready          decoder consumes inst this cycle
//     pc, pc_plus4        address of inst / outstanding request, and pc + 4
//     pc_src, br_taken,
//     imm, addr           next-PC controls, sampled on the consuming edge
//     fetch_count         delivered instructions (perf build only, else 0)
//     wait_count          memory wait cycles (perf build only, else 0)
//
//   Configuration macro: FETCH_PERF_EN enables the two performance counters.
//   When the macro is undefined, both counter ports are tied to 0.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  localparam int W_CPU    = 32,
  localparam int W_PC_SRC = 2,
  localparam int W_IMM    = 16,
  localparam int W_JADDR  = 26
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [W_CPU-1:0]    imem_addr,
  input  logic                imem_ack,
  input  logic [W_CPU-1:0]    imem_rdata,
  output logic [W_CPU-1:0]    inst,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [W_CPU-1:0]    pc,
  output logic [W_CPU-1:0]    pc_plus4,
  input  logic [W_PC_SRC-1:0] pc_src,
  input  logic                br_taken,
  input  logic [W_IMM-1:0]    imm,
  input  logic [W_JADDR-1:0]  addr,
  output logic [31:0]         fetch_count,
  output logic [31:0]         wait_count
);

  localparam logic [W_PC_SRC-1:0] PC_SRC_NEXT = 2'd0;
  localparam logic [W_PC_SRC-1:0] PC_SRC_BRCH = 2'd1;
  localparam logic [W_PC_SRC-1:0] PC_SRC_JUMP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_r;
  logic [W_CPU-1:0] pc_r;
  logic [W_CPU-1:0] inst_r;
  logic             imem_req_r;
  logic             inst_valid_r;

  logic [W_CPU-1:0] pc_plus4_s;
  logic [W_CPU-1:0] br_off_s;
  logic [W_CPU-1:0] next_pc_s;

  // pc_plus4 depends only on the PC register, so it stays a registered-only path
  assign pc_plus4_s = pc_r + 32'd4;

  // Next-PC select; the result is used only on the consuming HOLD edge
  always_comb begin
    br_off_s  = {{(W_CPU-W_IMM-2){imm[W_IMM-1]}}, imm, 2'b00};
    next_pc_s = pc_plus4_s;
    case (pc_src)
      PC_SRC_NEXT: next_pc_s = pc_plus4_s;
      PC_SRC_BRCH: begin
        if (br_taken) begin
          next_pc_s = pc_plus4_s + br_off_s;
        end else begin
          next_pc_s = pc_plus4_s;
        end
      end
      // Jump stays inside the 256 MB region of the delay-slot address
      PC_SRC_JUMP: next_pc_s = {pc_plus4_s[31:28], addr, 2'b00};
      default:     next_pc_s = pc_plus4_s;
    endcase
  end

  // Fetch FSM. The request and valid flags are registered with the state.
  // imem_ack is only looked at in REQ and inst_ready only in HOLD, so stray
  // handshakes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      pc_r         <= RESET_PC;
      inst_r       <= 32'd0;
      imem_req_r   <= 1'b0;
      inst_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r    <= REQ;
          imem_req_r <= 1'b1;
        end
        REQ: begin
          if (imem_ack) begin
            inst_r       <= imem_rdata;
            imem_req_r   <= 1'b0;
            inst_valid_r <= 1'b1;
            state_r      <= HOLD;
          end
        end
        HOLD: begin
          if (inst_ready) begin
            pc_r         <= next_pc_s;
            inst_valid_r <= 1'b0;
            imem_req_r   <= 1'b1;
            state_r      <= REQ;
          end
        end
        default: begin
          state_r      <= IDLE;
          imem_req_r   <= 1'b0;
          inst_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = imem_req_r;
  assign imem_addr  = pc_r;
  assign inst       = inst_r;
  assign inst_valid = inst_valid_r;
  assign pc         = pc_r;
  assign pc_plus4   = pc_plus4_s;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_r;
  logic [31:0] wait_count_r;

  // Performance counters: delivered words and memory wait cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_r <= 32'd0;
      wait_count_r  <= 32'd0;
    end else begin
      if ((state_r == HOLD) && inst_ready) begin
        fetch_count_r <= fetch_count_r + 32'd1;
      end
      if ((state_r == REQ) && !imem_ack) begin
        wait_count_r <= wait_count_r + 32'd1;
      end
    end
  end

  assign fetch_count = fetch_count_r;
  assign wait_count  = wait_count_r;
`else
  assign fetch_count = 32'd0;
  assign wait_count  = 32'd0;
`endif

endmodule
